// File: rtl/dadda_mul_arbiter_pkg.sv
// Shared widths and FSM state encoding for the shared 4x4 Dadda multiplier
// arbiter and its multiplier core.
package dadda_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dadda_mul_arbiter_if.sv
// Request/response bundle between the operand clients and the multiplier arbiter.
interface dadda_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import dadda_pkg::*;

  // A transfer happens on a rising edge where valid && ready. Once valid is
  // raised, the source holds its payload stable until it is accepted (a request
  // port may withdraw valid before its grant). Ready never depends on a
  // registered acceptance of the same cycle.
  logic [NUM_REQ-1:0]      req_valid;
  logic [OP_W*NUM_REQ-1:0] req_a;
  logic [OP_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [PROD_W-1:0]       rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );

endinterface

// File: rtl/dadda_mul_arbiter_mult.sv
// Combinational 4x4 unsigned Dadda multiplier: AND-array partial products,
// two reduction stages (height 4 -> 3 -> 2), then a final carry-propagate add.
module dadda_multiplier (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic p00, p01, p02, p03;
  logic p10, p11, p12, p13;
  logic p20, p21, p22, p23;
  logic p30, p31, p32, p33;

  // p<i><j> = a[j] & b[i], weight i+j
  assign p00 = a_i[0] & b_i[0];
  assign p01 = a_i[1] & b_i[0];
  assign p02 = a_i[2] & b_i[0];
  assign p03 = a_i[3] & b_i[0];
  assign p10 = a_i[0] & b_i[1];
  assign p11 = a_i[1] & b_i[1];
  assign p12 = a_i[2] & b_i[1];
  assign p13 = a_i[3] & b_i[1];
  assign p20 = a_i[0] & b_i[2];
  assign p21 = a_i[1] & b_i[2];
  assign p22 = a_i[2] & b_i[2];
  assign p23 = a_i[3] & b_i[2];
  assign p30 = a_i[0] & b_i[3];
  assign p31 = a_i[1] & b_i[3];
  assign p32 = a_i[2] & b_i[3];
  assign p33 = a_i[3] & b_i[3];

  // Stage 1: bring every column down to height 3
  logic s13, c13, s14, c14;
  assign s13 = p03 ^ p12;
  assign c13 = p03 & p12;
  assign s14 = p13 ^ p22;
  assign c14 = p13 & p22;

  // Stage 2: bring every column down to height 2
  logic s22, c22, s23, c23, s24, c24, s25, c25;
  assign s22 = p02 ^ p11;
  assign c22 = p02 & p11;
  assign s23 = s13 ^ p21 ^ p30;
  assign c23 = (s13 & p21) | (s13 & p30) | (p21 & p30);
  assign s24 = s14 ^ p31 ^ c13;
  assign c24 = (s14 & p31) | (s14 & c13) | (p31 & c13);
  assign s25 = p23 ^ p32 ^ c14;
  assign c25 = (p23 & p32) | (p23 & c14) | (p32 & c14);

  logic [7:0] row_x, row_y;
  assign row_x = {1'b0, p33, s25, s24, s23, s22, p01, p00};
  assign row_y = {c25, c24, c23, c22, p20, p10, 1'b0};
  assign p_o   = row_x + row_y;

endmodule

// File: rtl/dadda_mul_arbiter.sv
// Round-robin front end that shares one Dadda multiplier between NUM_REQ
// requesters, with registered operands and a registered, held result.
module dadda_mul_arbiter
  import dadda_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dadda_mul_arbiter_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [PROD_W-1:0] rsp_product_q, rsp_product_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [PROD_W-1:0]  mult_p;

  // First valid index at or after the pointer, wrapping; one-hot result.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [ID_W-1:0]    ptr
  );
    logic [NUM_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && v[idx[ID_W-1:0]]) begin
        g[idx[ID_W-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    pick     = rr_pick(bus.req_valid, rr_ptr_q);
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pick_idx = ID_W'(k);
    end
  end

  assign pick_any = |pick;

  dadda_multiplier u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mult_p)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    grant_id_d    = grant_id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    op_count_d    = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          op_a_d     = bus.req_a[pick_idx*OP_W +: OP_W];
          op_b_d     = bus.req_b[pick_idx*OP_W +: OP_W];
          grant_id_d = pick_idx;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        rsp_product_d = mult_p;
        rsp_id_d      = grant_id_q;
        rsp_valid_d   = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          // Fairness: the requester just served becomes lowest priority.
          rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                                            : grant_id_q + ID_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      grant_id_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      grant_id_q    <= grant_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
      op_count_q    <= op_count_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) ? pick : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign busy            = (state_q != S_IDLE);
  assign op_count        = op_count_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed and randomized checks of the shared-multiplier arbiter against a
// transaction-level round-robin/product model; a CNT_W=4 twin checks counter wrap.
module tb_dadda_mul_arbiter;
  import dadda_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  dadda_mul_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus16 ();
  dadda_mul_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus4 ();

  logic        busy16, busy4;
  logic [15:0] op_count16;
  logic [3:0]  op_count4;
  logic [1:0]  dbg16, dbg4;

  assign bus4.req_valid = bus16.req_valid;
  assign bus4.req_a     = bus16.req_a;
  assign bus4.req_b     = bus16.req_b;
  assign bus4.rsp_ready = bus16.rsp_ready;

  dadda_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus16),
    .busy      (busy16),
    .op_count  (op_count16),
    .dbg_state (dbg16)
  );

  dadda_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus4),
    .busy      (busy4),
    .op_count  (op_count4),
    .dbg_state (dbg4)
  );

  // Reference model state
  logic [3:0] a_v [4];
  logic [3:0] b_v [4];
  logic [7:0] exp_q [$];
  logic [1:0] exp_id_q [$];
  int         mdl_ptr   = 0;
  int         exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] mask);
    logic [1:0] ix;
    for (int k = 0; k < 4; k++) begin
      ix = 2'((mdl_ptr + k) % 4);
      if (mask[ix]) return int'(ix);
    end
    return -1;
  endfunction

  task automatic drive_reqs(input logic [3:0] mask);
    logic [15:0] pa, pb;
    for (int i = 0; i < 4; i++) begin
      pa[4*i +: 4] = a_v[i];
      pb[4*i +: 4] = b_v[i];
    end
    bus16.req_a     = pa;
    bus16.req_b     = pb;
    bus16.req_valid = mask;
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    bus16.req_valid = '0;
    bus16.rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", bus16.req_ready, 0);
    check("rst_rsp_valid", bus16.rsp_valid, 0);
    check("rst_rsp_id", bus16.rsp_id, 0);
    check("rst_rsp_product", bus16.rsp_product, 0);
    check("rst_busy", busy16, 0);
    check("rst_op_count", op_count16, 0);
    check("rst_op_count4", op_count4, 0);
    check("rst_state", dbg16, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    mdl_ptr   = 0;
    exp_count = 0;
    exp_q.delete();
    exp_id_q.delete();
  endtask

  // One complete transaction from an IDLE negedge; stall = cycles of rsp_ready low in DONE.
  task automatic run_op(input logic [3:0] mask, input int stall);
    int         g;
    logic [7:0] exp_p;
    logic [1:0] exp_id;
    g = model_pick(mask);
    drive_reqs(mask);
    bus16.rsp_ready = (stall == 0);
    #1;
    if (g < 0) begin
      check("idle_req_ready", bus16.req_ready, 0);
      @(negedge clk);
      check("idle_busy", busy16, 0);
      return;
    end
    check("grant", bus16.req_ready, 32'(4'b0001 << g));
    exp_q.push_back(8'(int'(a_v[g]) * int'(b_v[g])));
    exp_id_q.push_back(2'(g));
    @(negedge clk);
    check("calc_req_ready", bus16.req_ready, 0);
    check("calc_busy", busy16, 1);
    check("calc_rsp_valid", bus16.rsp_valid, 0);
    check("calc_state", dbg16, 1);
    @(negedge clk);
    exp_p  = exp_q.pop_front();
    exp_id = exp_id_q.pop_front();
    check("done_rsp_valid", bus16.rsp_valid, 1);
    check("done_rsp_id", bus16.rsp_id, exp_id);
    check("done_rsp_product", bus16.rsp_product, exp_p);
    check("done_state", dbg16, 2);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus16.rsp_valid, 1);
      check("hold_rsp_product", bus16.rsp_product, exp_p);
      check("hold_rsp_id", bus16.rsp_id, exp_id);
      check("hold_req_ready", bus16.req_ready, 0);
      check("hold_op_count", op_count16, 32'(exp_count % 65536));
    end
    bus16.rsp_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    mdl_ptr = (g + 1) % 4;
    check("end_rsp_valid", bus16.rsp_valid, 0);
    check("end_busy", busy16, 0);
    check("end_op_count", op_count16, 32'(exp_count % 65536));
    check("end_op_count4", op_count4, 32'(exp_count % 16));
    bus16.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] mask;
    int         g;
    bus16.req_valid = '0;
    bus16.req_a     = '0;
    bus16.req_b     = '0;
    bus16.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    #2;
    apply_reset();

    // Single requester 1: 3*5
    a_v[1] = 4'd3;
    b_v[1] = 4'd5;
    run_op(4'b0010, 0);

    // All four valid from reset: grants 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 4'(i + 1);
      b_v[i] = 4'd2;
    end
    for (int n = 0; n < 5; n++) run_op(4'b1111, 0);

    // Arithmetic corners and an idle cycle with nothing valid
    a_v[0] = 4'd15;
    b_v[0] = 4'd15;
    run_op(4'b0001, 1);
    a_v[2] = 4'd0;
    b_v[2] = 4'd9;
    run_op(4'b0100, 0);
    run_op(4'b0000, 0);

    // Result back-pressure for 5 cycles
    a_v[3] = 4'd7;
    b_v[3] = 4'd9;
    run_op(4'b1000, 5);

    // Reset in CALC: leave the pointer at 3 first, then abort a grant to 2
    a_v[2] = 4'd6;
    b_v[2] = 4'd11;
    run_op(4'b0100, 0);
    drive_reqs(4'b0100);
    @(negedge clk);
    check("pre_abort_busy", busy16, 1);
    rst_n           = 1'b0;
    bus16.req_valid = '0;
    #1;
    check("abort_rsp_valid", bus16.rsp_valid, 0);
    check("abort_rsp_product", bus16.rsp_product, 0);
    check("abort_rsp_id", bus16.rsp_id, 0);
    check("abort_busy", busy16, 0);
    check("abort_op_count", op_count16, 0);
    check("abort_req_ready", bus16.req_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    mdl_ptr   = 0;
    exp_count = 0;
    a_v[0] = 4'd4;
    b_v[0] = 4'd4;
    a_v[3] = 4'd2;
    b_v[3] = 4'd3;
    run_op(4'b1001, 0);

    // Exhaustive operand sweep under random contention and back-pressure
    for (int p = 0; p < 256; p++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        a_v[i] = 4'($urandom_range(0, 15));
        b_v[i] = 4'($urandom_range(0, 15));
      end
      g = model_pick(mask);
      a_v[g] = 4'(p / 16);
      b_v[g] = 4'(p % 16);
      run_op(mask, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
